imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time programming controller for the byte-celled instruction memory.
//  - Accepts 32-bit instruction words from a valid/ready stream.
//  - Serialises each word into 4 big-endian byte writes (MSB at lowest address),
//    matching the fetch-side word assembly {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
//  - Holds the CPU fetch/PC (cpu_hold) until the program image is fully loaded.
//  - Sits between the host/test loader stream and the imem write port.
// PARAMETERS
//  MEM_BYTES  `INSTR_MEM_SIZE  imem depth in byte cells; power of two, >= 4
//  WORD_W     `WORD_LEN (32)   instruction word width; must equal 4*CELL_W
//  CELL_W     `MEM_CELL_SIZE   byte cell width (8)
//  ADDR_W     $clog2(MEM_BYTES)  derived localparam, not overridable
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         asynchronous reset, active-high
//  start      in   1         1-cycle pulse: begin a load of load_len words at byte 0
//  load_len   in   ADDR_W-1  word count, sampled on the start cycle
//  s_valid    in   1         stream word valid
//  s_data     in   WORD_W    stream instruction word
//  s_ready    out  1         controller accepts s_data this cycle
//  mem_we     out  1         imem byte write enable
//  mem_addr   out  ADDR_W    imem byte address
//  mem_wdata  out  CELL_W    imem byte write data
//  cpu_hold   out  1         1 = CPU PC/fetch frozen
//  done       out  1         1 = image loaded, CPU running
//  err        out  1         1 = last start rejected (length overflow)
// BEHAVIOUR
//  Reset (async): state=IDLE; s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0,
//   cpu_hold=1, done=0, err=0; word_cnt=0, byte_idx=0. All outputs are registered.
//  States: IDLE, WAIT (s_ready=1), WRITE (4 cycles), RUN, ERR.
//  IDLE/RUN/ERR + start:
//   - load_len*4 > MEM_BYTES -> ERR (err=1, cpu_hold=1, done=0).
//   - load_len==0            -> RUN next cycle (done=1, cpu_hold=0, err=0).
//   - otherwise              -> WAIT; cpu_hold=1, done=0, err=0, word_cnt=0.
//   - RUN+start reloads: cpu_hold rises on the cycle after start.
//  WAIT: s_ready=1. Handshake is s_valid&s_ready; latch s_data, go to WRITE.
//   s_ready drops on the cycle after the handshake.
//  WRITE: byte_idx 0..3 over 4 consecutive cycles, mem_we=1;
//   mem_addr = word_cnt*4 + byte_idx;
//   mem_wdata = word[WORD_W-1-8*byte_idx -: CELL_W].
//   After byte 3: word_cnt++. If word_cnt==load_len -> RUN, else -> WAIT.
//  Timing: handshake at cycle t -> writes at t+1..t+4; next handshake at t+5 earliest.
//   Throughput is 1 word / 5 cycles.
//  RUN: done=1 and cpu_hold=0 in the cycle after the final byte write.
//  start while in WAIT/WRITE: ignored, no effect on the load in progress.
//  s_valid outside WAIT: ignored; the stream must hold the word until s_ready.
//  Address wrap is impossible: the length check guarantees mem_addr <= MEM_BYTES-1.
//  Reset mid-load: returns to IDLE immediately; imem contents are partial and
//   undefined; cpu_hold=1.
// STRUCTURE
//  Shared include imem_loader_defs.vh:
//   - state encodings (IDLE=0, WAIT=1, WRITE=2, RUN=3, ERR=4), 3 bits.
//   - BYTES_PER_WORD=4.
//   - Reuses `WORD_LEN / `INSTR_MEM_SIZE / `MEM_CELL_SIZE from defines.v.
//  Sub-module word_byte_serializer:
//   - loads a word, emits 4 MSB-first bytes with valid and last.
//   - the top level owns the FSM, counters and length check.
// TESTING
//  1. Reset, start len=2, words 0x20080005, 0x8C090004 ->
//     bytes 20 08 00 05 8C 09 00 04 at addrs 0..7; done=1 and cpu_hold=0 one cycle
//     after addr 7 is written.
//  2. Same load with s_valid held high continuously -> s_ready duty 1-in-5;
//     exactly 8 mem_we pulses.
//  3. start len=0 -> RUN on the next cycle, zero mem_we pulses;
//     start len=MEM_BYTES/4+1 -> err=1, cpu_hold=1, no writes.
//  4. Assert rst after 3 of 4 bytes of word 1 -> outputs return to reset values
//     asynchronously; a new start len=1 then loads cleanly at addr 0.
//  5. start pulses during WAIT/WRITE -> ignored;
//     start from RUN with len=1 -> cpu_hold=1 on the next cycle; reload of addrs 0..3.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the FSM state encoding and the default memory geometry.
package imem_boot_loader_pkg;

    localparam int unsigned DEF_MEM_BYTES  = 256;
    localparam int unsigned DEF_WORD_W     = 32;
    localparam int unsigned DEF_CELL_W     = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWait  = 3'd1,
        StWrite = 3'd2,
        StRun   = 3'd3,
        StErr   = 3'd4
    } state_e;

endpackage

// File: rtl/imem_boot_loader_word_byte_serializer.sv
// Loads one instruction word and emits its bytes MSB first, one per cycle,
// flagging the final byte with o_last.
module imem_boot_loader_word_byte_serializer
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned CELL_W = DEF_CELL_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    output logic [CELL_W-1:0] o_byte,
    output logic              o_valid,
    output logic              o_last
);

    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_idx;
    logic              r_valid;
    logic              w_last;

    assign w_last  = r_valid && (r_idx == 2'(BYTES_PER_WORD - 1));
    assign o_byte  = r_word[WORD_W-1 -: CELL_W];
    assign o_valid = r_valid;
    assign o_last  = w_last;

    // Shift left so the current byte always sits in the top cell.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid) begin
            r_word <= r_word << CELL_W;
            r_idx  <= r_idx + 2'd1;
            if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time imem programming controller: takes 32-bit words from a stream,
// writes them as big-endian bytes and holds the CPU until the image is loaded.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned CELL_W    = DEF_CELL_W,
    localparam int unsigned ADDR_W   = $clog2(MEM_BYTES)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-2:0] i_load_len,
    input  logic              i_s_valid,
    input  logic [WORD_W-1:0] i_s_data,
    output logic              o_s_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [CELL_W-1:0] o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);

    state_e            r_state, w_state_d;
    logic [ADDR_W-2:0] r_word_cnt, w_word_cnt_d;
    logic [ADDR_W-2:0] r_load_len, w_load_len_d;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
    logic              r_s_ready;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;

    logic              w_handshake;
    logic              w_ser_valid;
    logic              w_ser_last;
    logic [ADDR_W-2:0] w_cnt_inc;
    logic [31:0]       w_len_bytes;
    logic              w_len_over;

    assign w_handshake = r_s_ready && i_s_valid;
    assign w_cnt_inc   = r_word_cnt + 1'b1;
    assign w_len_bytes = 32'(i_load_len) * BYTES_PER_WORD;
    assign w_len_over  = w_len_bytes > MEM_BYTES;

    imem_boot_loader_word_byte_serializer #(
        .WORD_W (WORD_W),
        .CELL_W (CELL_W)
    ) u_serializer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_handshake),
        .i_word  (i_s_data),
        .o_byte  (o_mem_wdata),
        .o_valid (w_ser_valid),
        .o_last  (w_ser_last)
    );

    always_comb begin
        w_state_d    = r_state;
        w_word_cnt_d = r_word_cnt;
        w_load_len_d = r_load_len;
        w_mem_addr_d = r_mem_addr;
        // Address walks forward one cell per written byte, so word boundaries line up.
        if (w_ser_valid) begin
            w_mem_addr_d = r_mem_addr + ADDR_W'(1);
        end
        case (r_state)
            StIdle, StRun, StErr: begin
                if (i_start) begin
                    if (w_len_over) begin
                        w_state_d = StErr;
                    end else if (i_load_len == '0) begin
                        w_state_d = StRun;
                    end else begin
                        w_state_d    = StWait;
                        w_word_cnt_d = '0;
                        w_load_len_d = i_load_len;
                        w_mem_addr_d = '0;
                    end
                end
            end
            StWait: begin
                if (w_handshake) begin
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                if (w_ser_last) begin
                    w_word_cnt_d = w_cnt_inc;
                    w_state_d    = (w_cnt_inc == r_load_len) ? StRun : StWait;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Status outputs are registered from the next state so they track it cycle-exactly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_word_cnt <= '0;
            r_load_len <= '0;
            r_mem_addr <= '0;
            r_s_ready  <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_word_cnt <= w_word_cnt_d;
            r_load_len <= w_load_len_d;
            r_mem_addr <= w_mem_addr_d;
            r_s_ready  <= (w_state_d == StWait);
            r_cpu_hold <= (w_state_d != StRun);
            r_done     <= (w_state_d == StRun);
            r_err      <= (w_state_d == StErr);
        end
    end

    assign o_s_ready  = r_s_ready;
    assign o_mem_we   = w_ser_valid;
    assign o_mem_addr = r_mem_addr;
    assign o_cpu_hold = r_cpu_hold;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected byte writes are queued as
// words are offered and checked against every mem_we cycle.
module tb_imem_boot_loader;

    localparam int unsigned MEM_BYTES = 256;
    localparam int unsigned ADDR_W    = $clog2(MEM_BYTES);

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-2:0] load_len;
    logic              s_valid;
    logic [31:0]       s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    imem_boot_loader #(
        .MEM_BYTES (MEM_BYTES),
        .WORD_W    (32),
        .CELL_W    (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_load_len  (load_len),
        .i_s_valid   (s_valid),
        .i_s_data    (s_data),
        .o_s_ready   (s_ready),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_hold  (cpu_hold),
        .o_done      (done),
        .o_err       (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    int ready_cnt = 0;
    int last_we_cyc = 0;
    int exp_addr = 0;

    logic [15:0] exp_q[$];   // {addr, data}
    logic [31:0] stim_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (s_ready) ready_cnt++;
        if (mem_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("we_with_empty_queue", 64'(exp_q.size()), 64'd1);
            end else begin
                check_eq("write_addr_data", {48'd0, mem_addr, mem_wdata}, {48'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check_eq(tag, {s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err},
                 {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic start_load(input int len);
        start    = 1'b1;
        load_len = 7'(len);
        if (len > 0 && len * 4 <= MEM_BYTES) exp_addr = 0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back({8'(exp_addr + b), w[31 - 8 * b -: 8]});
        end
        exp_addr += 4;
    endtask

    // hold=1 keeps s_valid asserted across words; pulse=1 fires a stray start in WRITE.
    task automatic feed(input logic hold, input logic pulse);
        int prev_hs = -1;
        int waited;
        while (stim_q.size() > 0) begin
            logic [31:0] w;
            w = stim_q.pop_front();
            s_valid = 1'b1;
            s_data  = w;
            waited  = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!s_ready && waited < 20);
            if (!s_ready) begin
                check_eq("ready_timeout", {63'd0, s_ready}, 64'd1);
                s_valid = 1'b0;
                stim_q.delete();
                return;
            end
            push_word(w);
            if (hold && prev_hs >= 0) check_eq("handshake_spacing", 64'(cyc - prev_hs), 64'd5);
            prev_hs = cyc;
            @(posedge clk);
            #1;
            if (!hold) s_valid = 1'b0;
            if (pulse) begin
                start    = 1'b1;
                load_len = 7'd0;
                @(posedge clk);
                #1 start = 1'b0;
            end
            if (!hold && stim_q.size() > 0) begin
                repeat (7) @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!done && waited < 400);
        check_eq({tag, "_done"}, {63'd0, done}, 64'd1);
        check_eq({tag, "_done_latency"}, 64'(cyc - last_we_cyc), 64'd1);
        check_eq({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd0);
        check_eq({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_len = '0; s_valid = 1'b0; s_data = '0;
        #3 check_reset_vals("reset_initial");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic two-word load with a gap between words.
        we_cnt = 0;
        start_load(2);
        check_eq("t1_hold_in_wait", {62'd0, cpu_hold, s_ready}, 64'b11);
        stim_q = '{32'h20080005, 32'h8C090004};
        feed(1'b0, 1'b0);
        wait_done("t1");
        check_eq("t1_we_pulses", 64'(we_cnt), 64'd8);

        // Same load with s_valid held high: ready duty 1-in-5.
        we_cnt = 0; ready_cnt = 0;
        start_load(2);
        stim_q = '{32'h20080005, 32'h8C090004};
        feed(1'b1, 1'b0);
        wait_done("t2");
        check_eq("t2_we_pulses", 64'(we_cnt), 64'd8);
        check_eq("t2_ready_cycles", 64'(ready_cnt), 64'd2);

        // Zero-length and overflow starts.
        we_cnt = 0;
        start_load(0);
        check_eq("t3_len0_status", {61'd0, done, cpu_hold, err}, 64'b100);
        start_load(MEM_BYTES / 4 + 1);
        check_eq("t3_over_status", {61'd0, done, cpu_hold, err}, 64'b011);
        repeat (5) @(posedge clk);
        #1 check_eq("t3_no_writes", 64'(we_cnt), 64'd0);

        // Largest legal image fills the whole memory.
        start_load(MEM_BYTES / 4);
        check_eq("t3_full_err_clear", {63'd0, err}, 64'd0);
        for (int i = 0; i < MEM_BYTES / 4; i++) stim_q.push_back($urandom);
        feed(1'b1, 1'b0);
        wait_done("t3_full");
        check_eq("t3_full_we_pulses", 64'(we_cnt), 64'(MEM_BYTES));

        // Reset after three bytes of the first word.
        start_load(2);
        s_valid = 1'b1;
        s_data  = 32'hA1B2C3D4;
        begin
            int waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!s_ready && waited < 20);
        end
        push_word(32'hA1B2C3D4);
        @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset_vals("t4_async_reset");
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        we_cnt = 0;
        start_load(1);
        stim_q = '{32'h0F1E2D3C};
        feed(1'b0, 1'b0);
        wait_done("t4_reload");
        check_eq("t4_we_pulses", 64'(we_cnt), 64'd4);

        // Stray starts in WAIT and WRITE are ignored; start from RUN reloads.
        we_cnt = 0;
        start_load(1);
        start = 1'b1; load_len = 7'd3;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq("t5_wait_start_ignored", {62'd0, s_ready, cpu_hold}, 64'b11);
        stim_q = '{32'hDEADBEEF};
        feed(1'b0, 1'b1);
        wait_done("t5_first");
        check_eq("t5_first_we_pulses", 64'(we_cnt), 64'd4);
        check_eq("t5_err_clear", {63'd0, err}, 64'd0);
        we_cnt = 0;
        start_load(1);
        check_eq("t5_rerun_hold", {62'd0, cpu_hold, done}, 64'b10);
        stim_q = '{32'h13579BDF};
        feed(1'b0, 1'b0);
        wait_done("t5_rerun");
        check_eq("t5_rerun_we_pulses", 64'(we_cnt), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
